digit_scroller: RTL
===================

// Module: digit_scroller
// PURPOSE
//   Downstream stage of the scrolling-display path: accepts a 10-digit BCD
//   value (from binary2bcd of the scroller's outputNumber) and presents a
//   4-digit window to the 7-segment driver. Numbers of 4 or fewer significant
//   digits are shown statically; longer numbers scroll one digit per step,
//   most-significant first. When done, it pulses get_next_number upstream.
// PARAMETERS
//   TICKS_PER_STEP  100_000_000  clk cycles per display step (1 s @ 100 MHz)
//   HOLD_STEPS      2            steps the final (or only) window is held, >=1
// PORTS
//   clk              in   1   system clock, all state on rising edge
//   reset            in   1   asynchronous, active-high reset
//   load             in   1   1-cycle request: capture bcd_in (honoured in IDLE only)
//   bcd_in           in   40  10 BCD digits, digit9 = [39:36] ... digit0 = [3:0]
//   text             out  16  4-digit window to display stage, [15:12] leftmost
//   busy             out  1   high while a value is being shown/scrolled
//   get_next_number  out  1   1-cycle pulse: sequence finished, request next value
// BEHAVIOUR
//   Reset (async): state=IDLE, text=16'h0000, busy=0, get_next_number=0,
//     tick counter=0, pos=3, held digits=0. All outputs registered.
//   States: IDLE -> SHOW -> IDLE (get_next_number pulsed on the exit edge).
//   IDLE: on load, register bcd_in; ndig = 1 + index of highest nonzero nibble
//     (ndig=1 for all-zero); pos = max(ndig-1, 3); tick=0; busy<=1; ->SHOW.
//     text updates on the same edge (1-cycle latency from load).
//   Window: text = {digit[pos], digit[pos-1], digit[pos-2], digit[pos-3]}.
//   SHOW: tick counts 0..TICKS_PER_STEP-1; at terminal count tick<=0, one step ends.
//     pos>3: each step decrements pos by 1 (one step per window).
//     pos==3: window held for HOLD_STEPS steps (step counter), then on the edge
//       the last step ends: busy<=0, get_next_number<=1, ->IDLE.
//   get_next_number high exactly one cycle; cleared on next edge.
//   Total busy cycles = ((max(ndig,4)-4) + HOLD_STEPS) * TICKS_PER_STEP.
//   load while busy (SHOW) is ignored; held value and timing undisturbed.
//   load in the cycle get_next_number is high is accepted (state is IDLE):
//     allows back-to-back chaining with the upstream getNextNumber input.
//   In IDLE, text holds the last window shown (not cleared).
//   Non-decimal nibbles (A-F) are passed through unchanged; count as nonzero.
//   Leading zeros inside a <=4-digit value are displayed (0042 -> 16'h0042).
//   reset mid-SHOW: immediate return to reset values; no get_next_number pulse.
//   tick counter width = $clog2(TICKS_PER_STEP); pos 4 bits; step ctr >= $clog2(HOLD_STEPS+1).
// TESTING  (TICKS_PER_STEP=4, HOLD_STEPS=2)
//   load 40'h0000001234 -> text=16'h1234 next edge; busy 8 cycles; 1 pulse of
//     get_next_number on the edge busy falls; text stays 16'h1234 afterwards.
//   load 40'h9876543210 -> text 9876,8765,7654,6543,5432,4321 each 4 cycles,
//     then 3210 for 8 cycles; busy 32 cycles; single get_next_number pulse.
//   load 40'h0000012345 -> 16'h1234 for 4 cycles, 16'h2345 for 8; pulse after 12.
//   load 40'h0 -> text=16'h0000, busy 8 cycles, pulse; load again in pulse
//     cycle with 40'h0000000007 -> accepted, text=16'h0007 next edge.
//   load 40'h9876543210, second load 40'h1111 at cycle 5 -> ignored, scroll as above.
//   reset asserted mid-scroll (cycle 10) asynchronously -> text=0, busy=0,
//     no get_next_number pulse; next load behaves normally.

Source files
------------

// File: rtl/digit_scroller_if.sv
// Bundles the digit_scroller data path: BCD load request in, display window and status out.
interface digit_scroller_if;
  logic        load;
  logic [39:0] bcd_in;
  logic [15:0] text;
  logic        busy;
  logic        get_next_number;

  modport master (output load, bcd_in, input text, busy, get_next_number);
  modport slave  (input load, bcd_in, output text, busy, get_next_number);
endinterface

// File: rtl/digit_scroller.sv
// Presents a 4-digit window of a 10-digit BCD value, scrolling MSD-first when the
// value is longer than four digits, then requests the next value upstream.
module digit_scroller #(
  parameter int unsigned TICKS_PER_STEP = 100_000_000,
  parameter int unsigned HOLD_STEPS     = 2
) (
  input logic             clk,
  input logic             reset,
  digit_scroller_if.slave bus
);

  localparam int unsigned TICK_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam int unsigned STEP_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS + 1) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_STEP - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(HOLD_STEPS - 1);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t              state;
  logic [39:0]         digits;
  logic [3:0]          pos;
  logic [TICK_W-1:0]   tick;
  logic [STEP_W-1:0]   steps;
  logic [15:0]         text;
  logic                busy;
  logic                get_next_number;
  logic [3:0]          top_c;
  logic [3:0]          load_pos_c;

  // Window whose leftmost digit is digit[p]; p is always >= 3.
  function automatic logic [15:0] window(input logic [39:0] d, input logic [3:0] p);
    logic [39:0] sh;
    sh = d >> {p - 4'd3, 2'b00};
    return sh[15:0];
  endfunction

  // Starting window position: highest nonzero nibble, but never below digit 3.
  always_comb begin
    top_c = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (bus.bcd_in[4*i +: 4] != 4'h0) top_c = 4'(i);
    end
    load_pos_c = (top_c < 4'd3) ? 4'd3 : top_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      digits          <= 40'd0;
      pos             <= 4'd3;
      tick            <= '0;
      steps           <= '0;
      text            <= 16'h0000;
      busy            <= 1'b0;
      get_next_number <= 1'b0;
    end else begin
      get_next_number <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load) begin
            digits <= bus.bcd_in;
            pos    <= load_pos_c;
            tick   <= '0;
            steps  <= '0;
            text   <= window(bus.bcd_in, load_pos_c);
            busy   <= 1'b1;
            state  <= SHOW;
          end
        end
        SHOW: begin
          if (tick == TICK_LAST) begin
            tick <= '0;
            if (pos > 4'd3) begin
              pos  <= pos - 4'd1;
              text <= window(digits, pos - 4'd1);
            end else if (steps == STEP_LAST) begin
              steps           <= '0;
              busy            <= 1'b0;
              get_next_number <= 1'b1;
              state           <= IDLE;
            end else begin
              steps <= steps + STEP_W'(1);
            end
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.text            = text;
  assign bus.busy            = busy;
  assign bus.get_next_number = get_next_number;

endmodule
